mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only refills) and the data cache (refills and write-backs).
- Sits between the two cache controllers and the data/instruction memory model inside `system`.
- Round-robin arbitration; one transaction in flight at a time.
- Includes a sticky watchdog that flags a memory transaction that never completes.

Parameters:
ADDR_W, 6, block address width (64 blocks of 4 bytes)
DATA_W, 32, block data width
TIMEOUT, 200, cycles in a serve state before timeout_err sets (at most 255)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  asynchronous active-low reset (0 = reset)
i_read  input  1  instruction-cache block read request
i_address  input  ADDR_W  instruction-cache block address
i_readdata  output  DATA_W  block returned to instruction cache
i_busywait  output  1  stall to instruction cache
d_read  input  1  data-cache block read request
d_write  input  1  data-cache block write request
d_address  input  ADDR_W  data-cache block address
d_writedata  input  DATA_W  write-back block
d_readdata  output  DATA_W  block returned to data cache
d_busywait  output  1  stall to data cache
m_read  output  1  memory read strobe
m_write  output  1  memory write strobe
m_address  output  ADDR_W  memory block address
m_writedata  output  DATA_W  memory write data
m_readdata  input  DATA_W  memory read data
m_busywait  input  1  memory busy
grant  output  2  01 = instruction, 10 = data, 00 = none
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Requests: i_req = i_read; d_req = d_read | d_write. If d_read and d_write are both high, treat as a write; m_read is held 0.
- Reset (RESET=0, asynchronous, any time including mid-transaction):
  - state goes to IDLE; last_grant = data.
  - m_read, m_write, m_address, m_writedata, i_readdata, d_readdata, grant, timeout_err and the watchdog counter all clear to 0.
  - Memory strobes drop immediately, not at the next edge.
- States: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D.
- IDLE:
  - Only i_req: next state is SERVE_I.
  - Only d_req: next state is SERVE_D.
  - Both: grant the requester opposite to last_grant. The first tie after reset therefore goes to instruction.
  - On entering a serve state, register m_address, m_writedata, m_read/m_write and grant from the winning requester, and update last_grant.
  - Memory strobes are registered, so they appear 1 cycle after the request is seen in IDLE.
- SERVE_x:
  - Hold all m_* outputs stable.
  - Complete at the first rising edge where m_busywait == 0 and the state has been SERVE_x for at least 1 full cycle. This covers memory raising busywait combinationally off the strobe.
  - On completion: latch m_readdata into x_readdata (reads only; d_readdata is unchanged on writes), drop m_read/m_write, go to DONE_x.
- DONE_x:
  - Lasts exactly 1 cycle with grant = 00; go to IDLE.
  - Requests still asserted during DONE are ignored. The requester is expected to drop its request at the DONE edge.
  - A new request can be seen in the following IDLE cycle.
- busywait (combinational):
  - x_busywait = x_req, except 0 while in DONE_x.
  - The losing requester stays stalled throughout the winner's transaction.
  - Minimum uncontended read latency is 3 edges for a memory with zero wait states: IDLE→SERVE, SERVE→DONE, DONE→IDLE.
- x_readdata holds its last latched value until the next completed read for that requester.
- Watchdog:
  - An 8-bit counter clears on entering SERVE_x and increments each cycle in SERVE_x, saturating at 255.
  - When the count reaches TIMEOUT, timeout_err sets and stays set until reset.
  - The transaction keeps waiting; it is not aborted.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D.
- Address and data are captured at grant, so requester input changes mid-transaction have no effect.

Test Plan:
- Reset then i_read=1, i_address=6'h05; memory returns 32'hDEADBEEF after 5 busy cycles -> m_read=1 with m_address=05 one cycle later; i_readdata=DEADBEEF; i_busywait low for exactly the DONE cycle; grant back to 00.
- d_write=1, d_address=6'h12, d_writedata=32'h0A0B0C0D -> m_write=1 with m_address=12 and m_writedata=0A0B0C0D; m_read stays 0; d_readdata unchanged.
- i_read and d_read asserted the same cycle after reset, held 4 transactions -> grant sequence 01, 10, 01, 10; the non-granted busywait stays 1 throughout.
- TIMEOUT=10, memory holds m_busywait=1 for 15 cycles -> timeout_err rises at the 10th serve cycle; the read still completes at cycle 15 with correct data; timeout_err stays 1 afterwards.
- RESET pulled low during SERVE_D -> m_read/m_write, grant and busywaits go to 0 without waiting for CLK; after release, a pending i_read and d_read tie goes to instruction.
- d_read and d_write both high -> serviced as a write: m_write=1, m_read=0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundle of the instruction-cache, data-cache and
// main-memory handshake signals around the memory bus arbiter.
//   master : arbiter side (takes cache requests and memory responses,
//            drives the memory strobes, cache stalls and returned data)
//   slave  : environment side (caches and memory model)
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  // instruction cache
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  // data cache
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  // main memory
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_busywait;
  // status
  logic [1:0]        grant;
  logic              timeout_err;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           m_readdata, m_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
           m_read, m_write, m_address, m_writedata, grant, timeout_err
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           m_readdata, m_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
           m_read, m_write, m_address, m_writedata, grant, timeout_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single main-memory port between the
// instruction cache (read refills) and the data cache (refills and
// write-backs). Round-robin on ties, one transaction in flight, sticky
// watchdog on transactions that never finish.
// Ports:
//   CLK   - clock, all state on rising edge
//   RESET - asynchronous active-low reset
//   bus   - mem_bus_arbiter_if.master: i_*, d_* cache ports, m_* memory
//           port, grant (01 = instr, 10 = data, 00 = none), timeout_err
module mem_bus_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 200
) (
  input logic               CLK,
  input logic               RESET,
  mem_bus_arbiter_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_I = 3'd1;
  localparam logic [2:0] SERVE_D = 3'd2;
  localparam logic [2:0] DONE_I  = 3'd3;
  localparam logic [2:0] DONE_D  = 3'd4;

  // watchdog fires on the serve edge that takes the count to TIMEOUT
  localparam logic [7:0] WD_HIT = 8'(TIMEOUT - 1);

  logic [2:0]        state;
  logic              last_d;     // 1 = previous grant went to data cache
  logic [7:0]        wd_cnt;
  logic              i_req, d_req, pick_d;
  logic              win_rd, win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign i_req  = bus.i_read;
  assign d_req  = bus.d_read | bus.d_write;
  // data wins when alone, or on a tie when instruction had the last turn
  assign pick_d = d_req & (~i_req | ~last_d);

  // winning request as it will be captured on the IDLE -> SERVE edge;
  // read+write together from the data cache is a write
  always_comb begin
    win_addr  = bus.i_address;
    win_wdata = '0;
    win_rd    = 1'b1;
    win_wr    = 1'b0;
    if (pick_d) begin
      win_addr  = bus.d_address;
      win_wdata = bus.d_writedata;
      win_wr    = bus.d_write;
      win_rd    = ~bus.d_write;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= IDLE;
      last_d          <= 1'b1;
      wd_cnt          <= '0;
      bus.m_read      <= 1'b0;
      bus.m_write     <= 1'b0;
      bus.m_address   <= '0;
      bus.m_writedata <= '0;
      bus.i_readdata  <= '0;
      bus.d_readdata  <= '0;
      bus.grant       <= 2'b00;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state           <= pick_d ? SERVE_D : SERVE_I;
            last_d          <= pick_d;
            wd_cnt          <= '0;
            bus.grant       <= pick_d ? 2'b10 : 2'b01;
            bus.m_address   <= win_addr;
            bus.m_writedata <= win_wdata;
            bus.m_read      <= win_rd;
            bus.m_write     <= win_wr;
          end
        end
        SERVE_I, SERVE_D: begin
          if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'd1;
          if (wd_cnt == WD_HIT) bus.timeout_err <= 1'b1;
          // being in SERVE at an edge already means one full cycle has
          // passed, so a busywait raised combinationally off the strobe
          // is seen before completion
          if (!bus.m_busywait) begin
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
            bus.grant   <= 2'b00;
            if (state == SERVE_I) begin
              bus.i_readdata <= bus.m_readdata;
              state          <= DONE_I;
            end else begin
              if (bus.m_read) bus.d_readdata <= bus.m_readdata;
              state <= DONE_D;
            end
          end
        end
        DONE_I, DONE_D: state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // stall follows the request, released only for the requester's DONE
  // cycle; gated by reset so stalls drop without waiting for a clock
  assign bus.i_busywait = RESET & i_req & (state != DONE_I);
  assign bus.d_busywait = RESET & d_req & (state != DONE_D);

endmodule
